// File: rtl/mux_stim_gen.sv
// Seedable LFSR stimulus source for the 4:1 mux; emits NUM_TXN samples over valid/ready.
// Optional golden mux result output exp_out when MUX_STIM_GEN_REF_EN is defined.
module mux_stim_gen #(
  parameter int unsigned NUM_TXN = 20,
  parameter int unsigned DW      = 2,
  parameter logic [31:0] SEED    = 32'h0000_0321
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [DW-1:0] c,
  output logic [DW-1:0] d,
  output logic [1:0]    sel,
  output logic [15:0]   txn_cnt,
  output logic          busy,
`ifdef MUX_STIM_GEN_REF_EN
  output logic [DW-1:0] exp_out,
`endif
  output logic          done
);

  localparam int unsigned FW        = 4 * DW + 2;
  localparam logic [31:0] MASK      = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST      = 16'(NUM_TXN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [31:0]   lfsr;
  logic [31:0]   lfsr_nxt;
  logic [FW-1:0] fld;
  logic [15:0]   cnt_inc;
  logic          accept;

  // Galois step, and the field source: current state on start, stepped state on accept
  always_comb begin
    lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
    accept   = (state == RUN) & valid & ready;
    fld      = (state == RUN) ? lfsr_nxt[FW-1:0] : lfsr[FW-1:0];
    cnt_inc  = txn_cnt + 16'd1;
  end

`ifdef MUX_STIM_GEN_REF_EN
  logic [DW-1:0] exp_c;

  always_comb begin
    exp_c = fld[DW-1:0];
    case (fld[FW-1 -: 2])
      2'd0:    exp_c = fld[DW-1:0];
      2'd1:    exp_c = fld[2*DW-1 -: DW];
      2'd2:    exp_c = fld[3*DW-1 -: DW];
      default: exp_c = fld[4*DW-1 -: DW];
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= LFSR_INIT;
      valid   <= 1'b0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      d       <= '0;
      sel     <= '0;
      txn_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MUX_STIM_GEN_REF_EN
      exp_out <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            txn_cnt             <= '0;
            {sel, d, c, b, a}   <= fld;
`ifdef MUX_STIM_GEN_REF_EN
            exp_out             <= exp_c;
`endif
            valid               <= 1'b1;
            busy                <= 1'b1;
            done                <= 1'b0;
            state               <= RUN;
          end
        end
        RUN: begin
          // start is deliberately ignored here, even on the final accept
          if (accept) begin
            lfsr    <= lfsr_nxt;
            txn_cnt <= cnt_inc;
            if (cnt_inc == LAST) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              {sel, d, c, b, a} <= fld;
`ifdef MUX_STIM_GEN_REF_EN
              exp_out           <= exp_c;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_stim_gen.sv
// Self-checking bench for mux_stim_gen: directed scenarios plus randomized start/ready
// traffic compared against a transaction-level model.
module tb_mux_stim_gen;

  localparam int unsigned N    = 3;
  localparam int unsigned DW   = 2;
  localparam logic [31:0] SEED = 32'h0000_0321;
  localparam int unsigned VW   = 1 + 4 * DW + 2 + 16 + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ready;
  logic          valid;
  logic [DW-1:0] a, b, c, d;
  logic [1:0]    sel;
  logic [15:0]   txn_cnt;
  logic          busy;
  logic          done;
`ifdef MUX_STIM_GEN_REF_EN
  logic [DW-1:0] exp_out;
`endif

  int checks = 0;
  int errors = 0;

  mux_stim_gen #(.NUM_TXN(N), .DW(DW), .SEED(SEED)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ready   (ready),
    .valid   (valid),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .sel     (sel),
    .txn_cnt (txn_cnt),
    .busy    (busy),
`ifdef MUX_STIM_GEN_REF_EN
    .exp_out (exp_out),
`endif
    .done    (done)
  );

  always #5 clk = ~clk;

  // transaction-level model: a run is a count of accepts, the sample is a snapshot of the LFSR
  logic [31:0] m_lfsr;
  logic [31:0] m_fld;
  int          m_cnt;
  bit          m_run, m_valid, m_done;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic int unsigned fld_of(input logic [31:0] s, input int k);
    int unsigned w;
    w = (k == 4) ? 2 : DW;
    return (s >> (k * DW)) & ((32'd1 << w) - 1);
  endfunction

  function automatic int unsigned mux_of(input logic [31:0] s);
    return fld_of(s, int'(fld_of(s, 4)));
  endfunction

  function automatic void model_reset();
    m_lfsr  = SEED;
    m_fld   = '0;
    m_cnt   = 0;
    m_run   = 0;
    m_valid = 0;
    m_done  = 0;
  endfunction

  function automatic void model_edge();
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_cnt = 0; m_valid = 1; m_done = 0; m_fld = m_lfsr;
      end
    end else if (ready) begin
      m_lfsr = lfsr_step(m_lfsr);
      m_cnt++;
      if (m_cnt == N) begin
        m_run = 0; m_valid = 0; m_done = 1;
      end else begin
        m_fld = m_lfsr;
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, DW'(fld_of(m_fld, 0)), DW'(fld_of(m_fld, 1)), DW'(fld_of(m_fld, 2)),
            DW'(fld_of(m_fld, 3)), 2'(fld_of(m_fld, 4)), 16'(m_cnt), m_run, m_done};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {valid, a, b, c, d, sel, txn_cnt, busy, done};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs_vec(), {VW{1'b0}});
    end
`ifdef MUX_STIM_GEN_REF_EN
    checks++;
    if (exp_out !== '0) begin
      errors++;
      $display("FAIL reset_exp_out got %0d exp 0", exp_out);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_sample();
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if ({valid, a, b, c, d, sel, txn_cnt, busy} !== {1'b1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL first_sample got v%0d a%0d b%0d c%0d d%0d s%0d n%0d busy%0d exp v1 a1 b0 c2 d0 s3 n0 busy1",
               valid, a, b, c, d, sel, txn_cnt, busy);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL first_sample_model got %h exp %h", obs_vec(), exp_vec());
    end
`ifdef MUX_STIM_GEN_REF_EN
    checks++;
    if (exp_out !== 2'd0) begin
      errors++;
      $display("FAIL first_exp_out got %0d exp 0", exp_out);
    end
`endif
  endtask

  task automatic test_stall();
    logic [VW-1:0] held;
    held = obs_vec();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (obs_vec() !== held) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got %h exp %h", i, obs_vec(), held);
      end
    end
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    checks++;
    if ({valid, a, b, c, d, sel, txn_cnt} !== {1'b1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 16'd1}) begin
      errors++;
      $display("FAIL after_accept got v%0d a%0d b%0d c%0d d%0d s%0d n%0d exp v1 a3 b0 c1 d2 s1 n1",
               valid, a, b, c, d, sel, txn_cnt);
    end
`ifdef MUX_STIM_GEN_REF_EN
    checks++;
    if (exp_out !== 2'd0) begin
      errors++;
      $display("FAIL accept_exp_out got %0d exp 0", exp_out);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int accepts;
    int i;
    accepts = 0;
    i = 0;
    ready = 1'b1;
    while (!done && i < 10) begin
      if (valid) accepts++;
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_cycle%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      i++;
    end
    ready = 1'b0;
    checks++;
    if ({done, busy, valid, txn_cnt} !== {1'b1, 1'b0, 1'b0, 16'(N)} || accepts != N - 1) begin
      errors++;
      $display("FAIL b2b_done got done%0d busy%0d v%0d n%0d acc%0d exp done1 busy0 v0 n%0d acc%0d",
               done, busy, valid, txn_cnt, accepts, N, N - 1);
    end
  endtask

  task automatic test_restart();
    logic [31:0] s3;
    s3 = lfsr_step(lfsr_step(lfsr_step(SEED)));
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if ({done, valid, txn_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL restart_ctrl got done%0d v%0d n%0d exp done0 v1 n0", done, valid, txn_cnt);
    end
    checks++;
    if ({a, b, c, d, sel} !== {DW'(fld_of(s3, 0)), DW'(fld_of(s3, 1)), DW'(fld_of(s3, 2)),
                               DW'(fld_of(s3, 3)), 2'(fld_of(s3, 4))}) begin
      errors++;
      $display("FAIL restart_sample got a%0d b%0d c%0d d%0d s%0d exp a%0d b%0d c%0d d%0d s%0d",
               a, b, c, d, sel, fld_of(s3, 0), fld_of(s3, 1), fld_of(s3, 2), fld_of(s3, 3), fld_of(s3, 4));
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    cycle();
    cycle();
    ready = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs_vec(), {VW{1'b0}});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if ({valid, a, b, c, d, sel, txn_cnt} !== {1'b1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 16'd0}) begin
      errors++;
      $display("FAIL replay_sample got v%0d a%0d b%0d c%0d d%0d s%0d n%0d exp v1 a1 b0 c2 d0 s3 n0",
               valid, a, b, c, d, sel, txn_cnt);
    end
  endtask

  task automatic test_start_in_run();
    start = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      cycle();
      checks++;
      if (txn_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL start_in_run_cnt%0d got %0d exp %0d", i, txn_cnt, i + 1);
      end
    end
    start = 1'b0;
    ready = 1'b0;
    checks++;
    if ({done, busy, valid, txn_cnt} !== {1'b1, 1'b0, 1'b0, 16'(N)}) begin
      errors++;
      $display("FAIL start_in_run_done got done%0d busy%0d v%0d n%0d exp done1 busy0 v0 n%0d",
               done, busy, valid, txn_cnt, N);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 2) != 0);
      start = ($urandom_range(0, 5) == 0);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
`ifdef MUX_STIM_GEN_REF_EN
      checks++;
      if (exp_out !== DW'(mux_of(m_fld))) begin
        errors++;
        $display("FAIL random_exp_out_cyc%0d got %0d exp %0d", i, exp_out, mux_of(m_fld));
      end
`endif
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_stall();
    test_back_to_back();
    test_restart();
    test_async_reset();
    test_start_in_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
